// File: rtl/adc_scan_ctrl_if.sv
// rtl/adc_scan_ctrl_if.sv - Frame handshake and averaged-result bundle for adc_scan_ctrl
interface adc_scan_ctrl_if;
    logic        enable;
    logic [1:0]  chan_mask;
    logic        start;
    logic        done;
    logic [2:0]  channel;
    logic [11:0] data;
    logic        out_valid;
    logic        out_chan;
    logic [11:0] out_data;
    logic [11:0] result0;
    logic [11:0] result1;

    modport master (
        input  enable, chan_mask, done, data,
        output start, channel, out_valid, out_chan, out_data, result0, result1
    );

    modport slave (
        output enable, chan_mask, done, data,
        input  start, channel, out_valid, out_chan, out_data, result0, result1
    );
endinterface

// File: rtl/adc_scan_ctrl.sv
// rtl/adc_scan_ctrl.sv - Fixed-rate ADC frame sequencer with one-frame-late channel tagging
// and per-channel averaging of 2^AVG_LOG2 samples.
module adc_scan_ctrl #(
    parameter int PERIOD   = 100,
    parameter int AVG_LOG2 = 2
) (
    input  logic            clk,
    input  logic            reset,
    adc_scan_ctrl_if.master bus
);
    localparam int AW = 12 + AVG_LOG2;
    localparam int CW = AVG_LOG2 + 1;
    localparam int PW = $clog2(PERIOD);
    localparam logic [PW-1:0] LAST = PW'(PERIOD - 1);
    localparam logic [CW-1:0] FULL = CW'(1 << AVG_LOG2);

    typedef enum logic {IDLE, WAIT} state_e;

    state_e              state_q, state_d;
    logic [PW-1:0]       per_q, per_d;
    logic                primed_q, primed_d;
    logic                prev_q, prev_d;
    logic                ch_q, ch_d;
    logic                start_q, start_d;
    logic                ov_q, ov_d;
    logic                oc_q, oc_d;
    logic [11:0]         od_q, od_d;
    logic [11:0]         r0_q, r0_d;
    logic [11:0]         r1_q, r1_d;
    logic [1:0][AW-1:0]  acc_q, acc_d;
    logic [1:0][CW-1:0]  cnt_q, cnt_d;

    logic                tick;
    logic                next_ch;
    logic [AW-1:0]       sum;
    logic [CW-1:0]       cnt_inc;

    always_comb begin
        state_d  = state_q;
        per_d    = per_q;
        primed_d = primed_q;
        prev_d   = prev_q;
        ch_d     = ch_q;
        start_d  = 1'b0;
        ov_d     = 1'b0;
        oc_d     = oc_q;
        od_d     = od_q;
        r0_d     = r0_q;
        r1_d     = r1_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;

        tick    = (per_q == LAST);
        sum     = acc_q[prev_q] + AW'(bus.data);
        cnt_inc = cnt_q[prev_q] + CW'(1);

        if (!primed_q)
            next_ch = ~bus.chan_mask[0];
        else if (bus.chan_mask[~prev_q])
            next_ch = ~prev_q;
        else
            next_ch = prev_q;

        if (!bus.enable || tick)
            per_d = '0;
        else
            per_d = per_q + PW'(1);

        case (state_q)
            IDLE: begin
                if (tick && bus.enable && bus.chan_mask != 2'b00) begin
                    ch_d    = next_ch;
                    start_d = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // Data returned now belongs to the channel addressed one frame earlier.
                if (bus.done) begin
                    if (!primed_q) begin
                        primed_d = 1'b1;
                    end else if (cnt_inc == FULL) begin
                        ov_d = 1'b1;
                        oc_d = prev_q;
                        od_d = sum[AW-1:AVG_LOG2];
                        if (prev_q)
                            r1_d = sum[AW-1:AVG_LOG2];
                        else
                            r0_d = sum[AW-1:AVG_LOG2];
                        acc_d[prev_q] = '0;
                        cnt_d[prev_q] = '0;
                    end else begin
                        acc_d[prev_q] = sum;
                        cnt_d[prev_q] = cnt_inc;
                    end
                    prev_d  = ch_q;
                    state_d = IDLE;
                end
            end
        endcase

        // Landing in IDLE while disabled restarts the pipeline from scratch.
        if (!bus.enable && (state_q == IDLE || bus.done)) begin
            primed_d = 1'b0;
            acc_d    = '0;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            per_q    <= '0;
            primed_q <= 1'b0;
            prev_q   <= 1'b0;
            ch_q     <= 1'b0;
            start_q  <= 1'b0;
            ov_q     <= 1'b0;
            oc_q     <= 1'b0;
            od_q     <= '0;
            r0_q     <= '0;
            r1_q     <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            per_q    <= per_d;
            primed_q <= primed_d;
            prev_q   <= prev_d;
            ch_q     <= ch_d;
            start_q  <= start_d;
            ov_q     <= ov_d;
            oc_q     <= oc_d;
            od_q     <= od_d;
            r0_q     <= r0_d;
            r1_q     <= r1_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.start     = start_q;
    assign bus.channel   = {2'b00, ch_q};
    assign bus.out_valid = ov_q;
    assign bus.out_chan  = oc_q;
    assign bus.out_data  = od_q;
    assign bus.result0   = r0_q;
    assign bus.result1   = r1_q;
endmodule
